fxp_mult_arbiter: RTL
=====================

# fxp_mult_arbiter

Shares one pipelined signed fixed-point multiplier among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter issues at most one pair per cycle into an `LAT`-stage multiply/scale pipeline. Results return in issue order through a credit-protected output FIFO, tagged with the requester index. The block sits between the datapath clients and the shared multiplier resource.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..16.
- `WIDTH`, 16: total operand and result width, two's complement, sign bit included.
- `FRAC`, 8: fractional bits; legal range 0..`WIDTH`-1.
- `LAT`, 3: multiplier pipeline stages; legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_ready` out `NREQ`: per-requester grant; one-hot or zero.
- `req_a` in `NREQ`*`WIDTH`: operand A; requester i occupies bits [i*`WIDTH` +: `WIDTH`].
- `req_b` in `NREQ`*`WIDTH`: operand B, packed the same way.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out max(1,$clog2(`NREQ`)): index of the originating requester.
- `rsp_data` out `WIDTH`: scaled product.
- `rsp_ovf` out 1: the product fell outside the `WIDTH`-bit range.

## Operation
- Transfer on a request port: `req_valid[i] & req_ready[i]`. Transfer on the response port: `rsp_valid & rsp_ready`.
- Requesters must not make `req_valid` depend on `req_ready`. Once asserted, `req_valid` and operands are held until the transfer.
- Arbitration:
  - Round-robin. The pointer `last` holds the most recently granted index.
  - The search starts at `last`+1 and wraps at `NREQ`-1.
  - `last` updates only on a transfer. It resets to `NREQ`-1, so requester 0 wins first.
- Credit counter `outst` counts results in the pipeline plus results in the FIFO. Range 0..`DEPTH`, where `DEPTH`=`LAT`+1.
  - The arbiter grants only when the registered `outst` < `DEPTH`. There is no combinational path from `rsp_ready` to `req_ready`.
  - `outst` increments on a request transfer and decrements on a response transfer. Both in the same cycle leave it unchanged.
- Arithmetic:
  - `p` = signed(a) * signed(b), full 2*`WIDTH` bits.
  - `s` = `p` >>> `FRAC`; arithmetic shift, truncation toward -inf.
  - `rsp_ovf` = 1 when `s` > 2^(`WIDTH`-1)-1 or `s` < -2^(`WIDTH`-1), independent of configuration.
- Output FIFO:
  - `DEPTH` entries of {id, data, ovf}, strict FIFO order.
  - Cannot overflow, by construction of the credit counter. An overflow is a design error, flagged by an assertion.

## Timing
- Reset values: `req_ready`=0 (forced 0 while `rst_n` is low), `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_ovf`=0.
- Reset also clears `outst`=0, all pipeline valid bits, and the FIFO pointers.
- Latency: an operand transferred in cycle t produces `rsp_valid` in cycle t+`LAT` when the FIFO is empty.
- Throughput: one result per cycle sustained while `rsp_ready`=1, because steady-state `outst` stays ≤ `LAT` < `DEPTH`.
- Backpressure: with `rsp_ready`=0, at most `DEPTH` transfers are accepted. After that `req_ready`=0 until a response transfer lowers `outst`. `req_ready` rises the cycle after the decrement.
- `rsp_valid`, `rsp_id`, `rsp_data` and `rsp_ovf` hold stable while `rsp_valid` & !`rsp_ready`.
- Reset mid-operation drops all in-flight and buffered results. No stale `rsp_valid` appears after release.

## Configuration
- `FXP_MULT_ARB_SATURATE_EN` defined: when `rsp_ovf`=1, `rsp_data` clamps to 2^(`WIDTH`-1)-1 or -2^(`WIDTH`-1) by sign.
- Undefined: `rsp_data` = `s`[`WIDTH`-1:0], i.e. wrap-around.
- `rsp_ovf` behaves identically in both builds.

## Structure
- Shared package `fxp_ctrl_pkg` holds:
  - a response struct parameterised by widths, {id, data, ovf};
  - the range-check/saturate function;
  - the localparam rule `DEPTH`=`LAT`+1.
- Sub-module `fxp_mult_pipe`: `LAT`-stage valid/id/data pipeline doing multiply, shift and optional saturation. It carries no backpressure.
- Arbiter, credit counter and FIFO live in the top module.

## Test plan
All scenarios use `NREQ`=4, `WIDTH`=16, `FRAC`=8, `LAT`=3.
- Single request: requester 2 sends a=0x0180, b=0x0200 -> response 3 cycles later with `rsp_id`=2, `rsp_data`=0x0300, `rsp_ovf`=0.
- All four `req_valid` held high, `rsp_ready`=1 -> grants 0,1,2,3,0,1… one per cycle. Responses arrive back-to-back in the same id order.
- `rsp_ready`=0 with all requesting -> exactly 4 transfers, then `req_ready`=0. Raising `rsp_ready` drains 4 responses in order with no loss or duplication.
- Overflow cases:
  - a=0x7F00, b=0x0200 -> `rsp_ovf`=1; `rsp_data`=0x7FFF with the macro, 0xFE00 without.
  - a=0x8000, b=0x0200 -> `rsp_ovf`=1; `rsp_data`=0x8000 with the macro, 0x0000 without.
- Sign and truncation:
  - a=0xFF80, b=0x0080 -> 0xFFC0.
  - a=0x0001, b=0xFFFF -> 0xFFFF (floor).
- Reset mid-operation: `rst_n` low with 3 results in flight -> all outputs 0 immediately. After release there is no `rsp_valid` until a new request, and the first grant goes to requester 0.

Source files
------------

// File: rtl/fxp_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fxp_ctrl_pkg : shared sizing rule and range check for the        |
// |                fixed-point multiplier arbiter                    |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package fxp_ctrl_pkg;

  // Widest operand the range check supports; products are 2*MAX_W bits.
  localparam int unsigned MAX_W = 32;
  localparam int unsigned SW    = 2 * MAX_W;

  // One credit per pipeline stage plus one so the sustained stream never stalls.
  function automatic int unsigned fifo_depth(input int unsigned lat);
    return lat + 1;
  endfunction

  // 1 when the shifted product cannot be represented in w signed bits.
  function automatic logic range_ovf(input logic signed [SW-1:0] s, input int unsigned w);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_mult_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fxp_mult_arbiter_if : request and response bundle of the shared  |
// |                       multiplier arbiter                         |
// | Revision            : 1.0                                        |
// +------------------------------------------------------------------+
interface fxp_mult_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
  );
endinterface
`default_nettype wire

// File: rtl/fxp_mult_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fxp_mult_pipe : LAT-stage signed multiply, arithmetic shift and  |
// |                 optional clamp (FXP_MULT_ARB_SATURATE_EN)        |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module fxp_mult_pipe
  import fxp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned LAT   = 3,
  parameter int unsigned IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [IDW-1:0]   in_id_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  output logic [IDW-1:0]   out_id_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_ovf_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic signed [SW-1:0]      shifted_ext;
  logic                      ovf;
  logic [WIDTH-1:0]          res;

  logic [LAT-1:0]   v_q;
  logic [LAT-1:0]   ovf_q;
  logic [IDW-1:0]   id_q   [LAT];
  logic [WIDTH-1:0] data_q [LAT];

  assign prod        = (2*WIDTH)'($signed(in_a_i)) * (2*WIDTH)'($signed(in_b_i));
  assign shifted     = prod >>> FRAC;
  assign shifted_ext = SW'(shifted);
  assign ovf         = range_ovf(shifted_ext, WIDTH);

`ifdef FXP_MULT_ARB_SATURATE_EN
  always_comb begin
    res = shifted[WIDTH-1:0];
    if (ovf) begin
      res = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = shifted[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_valid_i;
      for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
    end
  end

  // Payload needs no reset: it is only observed alongside its valid bit.
  always_ff @(posedge clk) begin
    id_q[0]   <= in_id_i;
    data_q[0] <= res;
    ovf_q[0]  <= ovf;
    for (int i = 1; i < LAT; i++) begin
      id_q[i]   <= id_q[i-1];
      data_q[i] <= data_q[i-1];
      ovf_q[i]  <= ovf_q[i-1];
    end
  end

  assign out_valid_o = v_q[LAT-1];
  assign out_id_o    = id_q[LAT-1];
  assign out_data_o  = data_q[LAT-1];
  assign out_ovf_o   = ovf_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/fxp_mult_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fxp_mult_arbiter : round-robin sharing of one pipelined fixed-   |
// |   point multiplier; clamp option FXP_MULT_ARB_SATURATE_EN        |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module fxp_mult_arbiter
  import fxp_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned LAT   = 3,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fxp_mult_arbiter_if.slave   bus
);

  localparam int unsigned DEPTH = fifo_depth(LAT);
  localparam int unsigned PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             ovf;
  } rsp_t;

  logic [IDW-1:0]   last_q, last_d;
  logic [CNTW-1:0]  outst_q, outst_d;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             can_issue, issue;

  logic             p_valid, p_ovf;
  logic [IDW-1:0]   p_id;
  logic [WIDTH-1:0] p_data;
  rsp_t             p_rsp, head;

  rsp_t             mem_q [DEPTH];
  logic [PTRW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             empty, rsp_xfer, fifo_wr, fifo_rd;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Search begins one past the last winner and wraps at NREQ-1.
  always_comb begin : arb
    logic [IDW-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_q) + k) % NREQ);
      if (gnt == '0 && bus.req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        sel_a    = bus.req_a[idx*WIDTH +: WIDTH];
        sel_b    = bus.req_b[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign can_issue     = outst_q < CNTW'(DEPTH);
  assign bus.req_ready = (rst_n && can_issue) ? gnt : '0;
  assign issue         = rst_n && can_issue && (gnt != '0);
  assign last_d        = issue ? gnt_idx : last_q;

  fxp_mult_pipe #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .LAT   (LAT),
    .IDW   (IDW)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (issue),
    .in_id_i     (gnt_idx),
    .in_a_i      (sel_a),
    .in_b_i      (sel_b),
    .out_valid_o (p_valid),
    .out_id_o    (p_id),
    .out_data_o  (p_data),
    .out_ovf_o   (p_ovf)
  );

  // An empty FIFO passes the pipe output straight through so latency stays LAT.
  assign p_rsp = '{id: p_id, data: p_data, ovf: p_ovf};
  assign empty = (cnt_q == '0);
  assign head  = empty ? p_rsp : mem_q[rd_q];

  assign bus.rsp_valid = !empty || p_valid;
  assign bus.rsp_id    = bus.rsp_valid ? head.id   : '0;
  assign bus.rsp_data  = bus.rsp_valid ? head.data : '0;
  assign bus.rsp_ovf   = bus.rsp_valid ? head.ovf  : 1'b0;

  assign rsp_xfer = bus.rsp_valid && bus.rsp_ready;
  assign fifo_wr  = p_valid && !(empty && bus.rsp_ready);
  assign fifo_rd  = rsp_xfer && !empty;
  assign wr_d     = fifo_wr ? ptr_inc(wr_q) : wr_q;
  assign rd_d     = fifo_rd ? ptr_inc(rd_q) : rd_q;
  assign cnt_d    = cnt_q + CNTW'(fifo_wr) - CNTW'(fifo_rd);

  always_comb begin
    outst_d = outst_q;
    if (issue && !rsp_xfer) begin
      outst_d = outst_q + CNTW'(1);
    end else if (!issue && rsp_xfer) begin
      outst_d = outst_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= IDW'(NREQ - 1);
      outst_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      outst_q <= outst_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_q] <= p_rsp;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && !fifo_rd && (cnt_q == CNTW'(DEPTH))));

endmodule
`default_nettype wire
